seq_capture_channel: RTL



---
 rtl/seq_capture_channel.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seq_capture_channel.sv
// Pulse-train capture channel: measures the high and low durations of an asynchronous input in clk cycles.
// Results, an edge count and status are exposed on the shared register bus (REGBASE+0..+4).
module seq_capture_channel #(
    parameter logic [15:0] REGBASE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
    output logic        strobe,
    input  logic        reg_clk,
    input  logic [15:0] reg_addr,
    inout  wire  [31:0] reg_data,
    input  logic        reg_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // ---------------------------------------------------------------- register bus (reg_clk)
    logic [15:0] reg_offset;
    logic        reg_hit;
    logic [1:0]  cfg_q;
    logic [31:0] ro_src  [4];
    logic [31:0] ro_meta [4];
    logic [31:0] ro_q    [4];
    logic [31:0] rd_data;

    assign reg_offset = reg_addr - REGBASE;
    assign reg_hit    = (reg_addr >= REGBASE) && (reg_offset <= 16'd4);

    always_ff @(posedge reg_clk) begin
        if (reset) begin
            cfg_q <= '0;
        end else if (reg_wr && reg_hit && (reg_offset == 16'd0)) begin
            cfg_q <= reg_data[1:0];
        end
    end

    // NOTE: the readback shadows are few and hold visible bus state, so they take the reset like any flop.
    always_ff @(posedge reg_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ro_meta[i] <= '0;
                ro_q[i]    <= '0;
            end
        end else begin
            ro_meta <= ro_src;
            ro_q    <= ro_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_data = '0;
        case (reg_offset)
            16'd0:   rd_data = {30'd0, cfg_q};
            16'd1:   rd_data = ro_q[0];
            16'd2:   rd_data = ro_q[1];
            16'd3:   rd_data = ro_q[2];
            16'd4:   rd_data = ro_q[3];
            default: rd_data = '0;
        endcase
    end

    assign reg_data = (reg_hit && !reg_wr) ? rd_data : 'z;

    // ---------------------------------------------------------------- capture logic (clk)
    logic [1:0]  cfg_meta, cfg_sync;
    logic        clear_d;
    logic        in_meta, s, s_d;
    logic        enable, clear_pulse, edge_det;
    state_t      state_q, state_d;
    logic [31:0] counter, high_len, low_len, edge_count;
    logic        high_valid, low_valid, overflow;
    logic        do_clear, cnt_zero, cnt_restart, cnt_inc, edge_inc, latch_high, latch_low;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_meta <= '0;
            cfg_sync <= '0;
            clear_d  <= 1'b0;
            in_meta  <= 1'b0;
            s        <= 1'b0;
            s_d      <= 1'b0;
        end else begin
            cfg_meta <= cfg_q;
            cfg_sync <= cfg_meta;
            clear_d  <= cfg_sync[1];
            in_meta  <= in;
            s        <= in_meta;
            s_d      <= s;
        end
    end

    assign enable      = cfg_sync[0];
    assign clear_pulse = cfg_sync[1] & ~clear_d;
    assign edge_det    = (s ^ s_d) & enable;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_pulse) begin
            state_d = enable ? ARMED : IDLE;
        end else if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = edge_det ? MEAS : ARMED;
                MEAS:    state_d = MEAS;
                default: state_d = IDLE;
            endcase
        end
    end

    // Clear outranks everything, including an edge seen in the same cycle.
    always_comb begin
        do_clear    = 1'b0;
        cnt_zero    = 1'b0;
        cnt_restart = 1'b0;
        cnt_inc     = 1'b0;
        edge_inc    = 1'b0;
        latch_high  = 1'b0;
        latch_low   = 1'b0;
        if (clear_pulse) begin
            do_clear = 1'b1;
        end else if (!enable) begin
            cnt_zero = 1'b1;
        end else begin
            case (state_q)
                ARMED: begin
                    cnt_restart = edge_det;
                    edge_inc    = edge_det;
                end
                MEAS: begin
                    cnt_restart = edge_det;
                    edge_inc    = edge_det;
                    latch_high  = edge_det & ~s;
                    latch_low   = edge_det & s;
                    cnt_inc     = ~edge_det;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            counter    <= '0;
            high_len   <= '0;
            low_len    <= '0;
            edge_count <= '0;
            high_valid <= 1'b0;
            low_valid  <= 1'b0;
            overflow   <= 1'b0;
            strobe     <= 1'b0;
        end else begin
            strobe <= latch_high | latch_low;
            if (cnt_zero) begin
                counter <= '0;
            end else if (cnt_restart) begin
                counter <= 32'd1;
            end else if (cnt_inc && (counter != CNT_MAX)) begin
                counter <= counter + 32'd1;
            end
            // Sticky once the count is about to reach, or already sits at, saturation.
            if (cnt_inc && (counter[31:1] == 31'h7FFF_FFFF)) begin
                overflow <= 1'b1;
            end
            if (latch_high) begin
                high_len   <= counter;
                high_valid <= 1'b1;
            end
            if (latch_low) begin
                low_len   <= counter;
                low_valid <= 1'b1;
            end
            if (edge_inc) begin
                edge_count <= edge_count + 32'd1;
            end
        end
    end

    assign ro_src[0] = high_len;
    assign ro_src[1] = low_len;
    assign ro_src[2] = edge_count;
    assign ro_src[3] = {26'd0, state_q, s, overflow, low_valid, high_valid};

endmodule
